// File: rtl/multi_interval_timer.sv
// CH-channel programmable interval timer with shadowed periods and one-shot/periodic modes.
// Optional shared step prescaler enabled by defining MIT_PRESCALER_EN.
module multi_interval_timer #(
  parameter int CH         = 4,
  parameter int CW         = 27,
  parameter int DEF_PERIOD = 100000000,
  parameter int PRE_DIV    = 1000,
  localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  run,
  input  logic [CH-1:0]  periodic,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  output logic [CH-1:0]  tick,
  output logic [CH-1:0]  done,
  output logic [CH-1:0]  active
);

  localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);

  logic [CW-1:0] count_r  [CH];
  logic [CW-1:0] period_r [CH];
  logic [CW-1:0] shadow_r [CH];
  logic [CH-1:0] tick_r;
  logic [CH-1:0] done_r;
  logic [CH-1:0] active_r;
  logic          step_s;

`ifdef MIT_PRESCALER_EN
  localparam int            PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

  logic [PW-1:0] pre_cnt_r;

  // Free-running prescaler, independent of run; wraps every PRE_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_r <= '0;
    end else if (pre_cnt_r == PRE_LAST) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1'b1);
    end
  end

  assign step_s = (pre_cnt_r == PRE_LAST);
`else
  localparam int unused_pre_div = PRE_DIV;

  assign step_s = 1'b1;
`endif

  // Per-channel shadow/live period, interval counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        count_r[i]  <= '0;
        period_r[i] <= DEF_P;
        shadow_r[i] <= DEF_P;
      end
      tick_r   <= '0;
      done_r   <= '0;
      active_r <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        // Index compare on the full cfg_ch value, so out-of-range indices match nothing.
        if (cfg_we && (int'(cfg_ch) == i)) begin
          shadow_r[i] <= cfg_period;
        end
        tick_r[i] <= 1'b0;
        if (!run[i]) begin
          count_r[i]  <= '0;
          done_r[i]   <= 1'b0;
          active_r[i] <= 1'b0;
          period_r[i] <= shadow_r[i];
        end else if (step_s) begin
          if ((period_r[i] == '0) || done_r[i]) begin
            count_r[i]  <= '0;
            active_r[i] <= 1'b0;
          end else if ((count_r[i] + CW'(1'b1)) == period_r[i]) begin
            // Expiry: wrap, pick up any pending period, one-shot parks in done.
            tick_r[i]   <= 1'b1;
            count_r[i]  <= '0;
            period_r[i] <= shadow_r[i];
            done_r[i]   <= ~periodic[i];
            active_r[i] <= periodic[i];
          end else begin
            count_r[i]  <= count_r[i] + CW'(1'b1);
            active_r[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign tick   = tick_r;
  assign done   = done_r;
  assign active = active_r;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Scoreboard bench for multi_interval_timer: expected tick cycles are queued per
// channel by the stimulus and consumed by a tick monitor on the falling edge.
module tb_multi_interval_timer;

  localparam int CH         = 5;
  localparam int CW         = 27;
  localparam int DEF_PERIOD = 20;
  localparam int PRE_DIV    = 4;
  localparam int CHW        = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [CH-1:0]  run = '0;
  logic [CH-1:0]  periodic = '0;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic [CH-1:0]  tick;
  logic [CH-1:0]  done;
  logic [CH-1:0]  active;

  int total = 0;
  int bad   = 0;
  int cyc;
  int exp_q [CH][$];

  multi_interval_timer #(
    .CH(CH), .CW(CW), .DEF_PERIOD(DEF_PERIOD), .PRE_DIV(PRE_DIV)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .periodic(periodic),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .tick(tick), .done(done), .active(active)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Tick monitor: every observed tick must match the head of its channel queue.
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        if (tick[c]) begin
          if (exp_q[c].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tick ch%0d: got tick at cyc %0d expected none", c, cyc);
          end else begin
            e = exp_q[c].pop_front();
            check($sformatf("tick_cyc_ch%0d", c), cyc, e);
          end
        end
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input int ch, input int p);
    cfg_we     = 1'b1;
    cfg_ch     = ch[CHW-1:0];
    cfg_period = p[CW-1:0];
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic push(input int ch, input int t);
    exp_q[ch].push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({tick, done, active}), 0);
    rst = 1'b0;

`ifdef MIT_PRESCALER_EN
    // P=2 with steps every 4 clk: ticks every 8 clk.
    cfg_write(0, 2);
    at(2);  run[0] = 1'b1; periodic[0] = 1'b1;
    push(0, 8); push(0, 16); push(0, 24);
    at(3);  check("pre_active_before_step", int'(active[0]), 0);
    at(5);  check("pre_active_after_step", int'(active[0]), 1);
    at(26); run[0] = 1'b0;
    at(28); check("pre_active_cleared", int'(active[0]), 0);
`else
    // CH0 P=5 periodic.
    cfg_write(0, 5);
    at(2);  run[0] = 1'b1; periodic[0] = 1'b1;
    push(0, 7); push(0, 12); push(0, 17);
    at(3);  check("ch0_active", int'(active[0]), 1);
    at(18); run[0] = 1'b0;
    at(20); check("ch0_idle", int'(active[0]), 0);

    // CH1 P=3 one-shot, then re-arm through run low.
    cfg_write(1, 3);
    at(22); run[1] = 1'b1; periodic[1] = 1'b0;
    push(1, 25);
    at(27); check("ch1_done", int'(done[1]), 1);
            check("ch1_inactive", int'(active[1]), 0);
    at(30); run[1] = 1'b0;
    at(31); check("ch1_done_cleared", int'(done[1]), 0);
            run[1] = 1'b1;
    push(1, 34);
    at(40); check("ch1_done_again", int'(done[1]), 1);
            run[1] = 1'b0;

    // CH2 P=10, new period 4 written at count 6: old interval completes.
    at(41); cfg_write(2, 10);
    at(43); run[2] = 1'b1; periodic[2] = 1'b1;
    push(2, 53); push(2, 57); push(2, 61);
    at(49); cfg_write(2, 4);
    at(62); run[2] = 1'b0;

    // CH3 run dropped on the expiry cycle.
    at(64); cfg_write(3, 4);
    at(66); run[3] = 1'b1; periodic[3] = 1'b0;
    at(69); run[3] = 1'b0;
    at(70); check("ch3_no_done", int'(done[3]), 0);
            check("ch3_no_active", int'(active[3]), 0);
    at(71); run[3] = 1'b1;
    push(3, 75);
    at(76); check("ch3_done", int'(done[3]), 1);
    at(77); run[3] = 1'b0;

    // P=0 inert, P=1 every cycle, out-of-range cfg_ch ignored.
    at(78); cfg_write(0, 0);
    at(80); run[0] = 1'b1; periodic[0] = 1'b1;
    at(90); check("p0_inactive", int'(active[0]), 0);
            check("p0_no_done", int'(done[0]), 0);
            run[0] = 1'b0;
    at(91); cfg_write(1, 1);
    at(93); run[1] = 1'b1; periodic[1] = 1'b1;
    for (int t = 94; t <= 98; t++) push(1, t);
    at(98); run[1] = 1'b0;
    at(100); cfg_write(5, 2);
    at(102); run[1] = 1'b1;
    push(1, 103); push(1, 104); push(1, 105);
    at(105); run[1] = 1'b0;

    // Simultaneous expiries, then async reset restores default periods.
    at(106); run[2] = 1'b1; periodic[2] = 1'b1; run[3] = 1'b1; periodic[3] = 1'b0;
    push(2, 110); push(3, 110);
    at(111); check("ch3_done_pre_rst", int'(done[3]), 1);
    at(112); #2; rst = 1'b1;
    #1;      check("async_rst_outputs", int'({tick, done, active}), 0);
    repeat (2) @(posedge clk);
    #1;      rst = 1'b0;
    push(2, DEF_PERIOD); push(3, DEF_PERIOD);
    at(22); check("ch2_active_post_rst", int'(active[2]), 1);
            run[2] = 1'b0;
    at(25); check("ch3_done_post_rst", int'(done[3]), 1);
    at(26); run[3] = 1'b0;
`endif
    at(cyc + 3);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("pending_ticks_ch%0d", c), exp_q[c].size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
